// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EX stage (DIV/DIVU).
// One quotient bit per cycle; result is {remainder, quotient} and is held while start_i stays high.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t                 state_reg, state_next;
    logic [CW-1:0]          cnt_reg;
    logic [WIDTH-1:0]       divisor_reg;
    logic [WIDTH-1:0]       quo_reg;
    logic [WIDTH:0]         rem_reg;
    logic                   neg_quo_reg;
    logic                   neg_rem_reg;
    logic [2*WIDTH-1:0]     result_reg, result_next;
    logic                   ready_reg, ready_next;

    logic                   accept;
    logic                   last_iter;
    logic                   divisor_zero;
    logic [WIDTH-1:0]       op1_abs, op2_abs;
    logic [WIDTH+1:0]       shifted, diff;
    logic                   take;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    assign accept       = start_i && !annul_i;
    assign last_iter    = (cnt_reg == CW'(WIDTH - 1));
    assign divisor_zero = (opdata2_i == '0);

    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Partial remainder is kept one bit wider so the shifted trial value never overflows.
    assign shifted = {rem_reg, quo_reg[WIDTH-1]};
    assign diff    = shifted - {2'b00, divisor_reg};
    assign take    = ~diff[WIDTH+1];

    // Two's-complement fix-up wraps modulo 2^WIDTH, so MIN / -1 returns MIN without a trap.
    assign quo_fix = neg_quo_reg ? (~quo_reg + 1'b1) : quo_reg;
    assign rem_fix = neg_rem_reg ? (~rem_reg[WIDTH-1:0] + 1'b1) : rem_reg[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_FREE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FREE: begin
                if (accept) begin
                    state_next = divisor_zero ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                state_next = S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_next = S_FREE;
                end else if (last_iter) begin
                    state_next = S_END;
                end
            end
            S_END: begin
                if (!start_i) begin
                    state_next = S_FREE;
                end
            end
            default: begin
                state_next = S_FREE;
            end
        endcase
    end

    // The result is published only while the requester still holds start_i.
    always_comb begin
        ready_next  = 1'b0;
        result_next = '0;
        if (state_reg == S_END && start_i) begin
            ready_next  = 1'b1;
            result_next = {rem_fix, quo_fix};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            divisor_reg <= '0;
            quo_reg     <= '0;
            rem_reg     <= '0;
            neg_quo_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_FREE: begin
                    cnt_reg <= '0;
                    if (accept) begin
                        divisor_reg <= op2_abs;
                        quo_reg     <= op1_abs;
                        rem_reg     <= '0;
                        neg_quo_reg <= signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_reg <= signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
                S_BYZERO: begin
                    quo_reg     <= '0;
                    rem_reg     <= '0;
                    neg_quo_reg <= 1'b0;
                    neg_rem_reg <= 1'b0;
                end
                S_ON: begin
                    if (!annul_i) begin
                        rem_reg <= take ? diff[WIDTH:0] : shifted[WIDTH:0];
                        quo_reg <= {quo_reg[WIDTH-2:0], take};
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: begin
                end
            endcase
            result_reg <= result_next;
            ready_reg  <= ready_next;
        end
    end

    assign result_o = result_reg;
    assign ready_o  = ready_reg;

endmodule

// File: tb/tb_div_iter.sv
// Randomised and directed checks of div_iter at WIDTH 32 and 8 against an arithmetic model.
// One line is printed per completed divide.
module tb_div_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sg32, st32, an32;
    logic [31:0] a32, b32;
    logic [63:0] res32;
    logic        rdy32;
    logic        sg8, st8, an8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8;

    int n_cmp  = 0;
    int n_fail = 0;

    div_iter #(.WIDTH(32)) u_div32 (
        .clk(clk), .rst(rst), .signed_div_i(sg32), .opdata1_i(a32), .opdata2_i(b32),
        .start_i(st32), .annul_i(an32), .result_o(res32), .ready_o(rdy32)
    );

    div_iter #(.WIDTH(8)) u_div8 (
        .clk(clk), .rst(rst), .signed_div_i(sg8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(st8), .annul_i(an8), .result_o(res8), .ready_o(rdy8)
    );

    // Reference: plain integer division on w-bit operands, returns {rem[31:0], quo[31:0]}.
    function automatic logic [63:0] model(input int w, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint mask, av, bv, q, r;
        mask = (longint'(1) << w) - 1;
        av = longint'(a) & mask;
        bv = longint'(b) & mask;
        if (sgn) begin
            if (((av >> (w - 1)) & 1) == 1) av = av - (longint'(1) << w);
            if (((bv >> (w - 1)) & 1) == 1) bv = bv - (longint'(1) << w);
        end
        if (bv == 0) return 64'd0;
        q = av / bv;
        r = av % bv;
        return {32'(r & mask), 32'(q & mask)};
    endfunction

    function automatic logic [63:0] get_res(input int w);
        return (w == 32) ? res32 : {48'd0, res8};
    endfunction

    function automatic logic get_rdy(input int w);
        return (w == 32) ? rdy32 : rdy8;
    endfunction

    task automatic drive(input int w, input bit st, input bit sg,
                         input logic [31:0] a, input logic [31:0] b, input bit an);
        if (w == 32) begin
            st32 = st; sg32 = sg; a32 = a; b32 = b; an32 = an;
        end else begin
            st8 = st; sg8 = sg; a8 = a[7:0]; b8 = b[7:0]; an8 = an;
        end
    endtask

    // Waits for ready after the start edge; returns the number of edges taken (0 on timeout).
    task automatic wait_ready(input int w, output int lat, output bit seen_nz);
        lat = 0;
        seen_nz = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (get_rdy(w)) begin
                lat = k;
                break;
            end
            if (get_res(w) !== 64'd0) seen_nz = 1'b1;
        end
    endtask

    task automatic run_op(input int w, input string name, input bit sgn,
                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m, exp_res;
        int lat, exp_lat;
        bit seen_nz, bz;
        m = model(w, sgn, a, b);
        bz = (w == 32) ? (b == 32'd0) : (b[7:0] == 8'd0);
        exp_lat = bz ? 2 : w + 1;
        exp_res = (w == 32) ? m : {48'd0, m[39:32], m[7:0]};
        @(negedge clk); drive(w, 1'b1, sgn, a, b, 1'b0);
        @(posedge clk);
        wait_ready(w, lat, seen_nz);
        n_cmp++;
        if (lat != exp_lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        n_cmp++;
        if (seen_nz) begin
            n_fail++;
            $display("FAIL %s result_nonzero_before_ready: got nonzero expected 0", name);
        end
        n_cmp++;
        if (get_res(w) !== exp_res) begin
            n_fail++;
            $display("FAIL %s result: got %h expected %h", name, get_res(w), exp_res);
        end
        $display("[%0t] W=%0d %s sgn=%0d a=%h b=%h result=%h lat=%0d", $time, w, name,
                 sgn, a, b, get_res(w), lat);
        // Scramble operands and raise annul while holding start: the result must not move.
        @(negedge clk); drive(w, 1'b1, ~sgn, $urandom, $urandom, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (get_rdy(w) !== 1'b1 || get_res(w) !== exp_res) begin
            n_fail++;
            $display("FAIL %s hold: got rdy=%b res=%h expected rdy=1 res=%h", name,
                     get_rdy(w), get_res(w), exp_res);
        end
        @(negedge clk); drive(w, 1'b0, sgn, a, b, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (get_rdy(w) !== 1'b0 || get_res(w) !== 64'd0) begin
            n_fail++;
            $display("FAIL %s clear: got rdy=%b res=%h expected rdy=0 res=0", name,
                     get_rdy(w), get_res(w));
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(32, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        drive(8, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        @(posedge clk); #1;
        n_cmp++;
        if (rdy32 !== 1'b0 || res32 !== 64'd0 || rdy8 !== 1'b0 || res8 !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy32=%b res32=%h rdy8=%b res8=%h expected all 0",
                     rdy32, res32, rdy8, res8);
        end
        @(negedge clk);
        drive(32, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        drive(8, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_directed;
        run_op(32, "u100/7", 1'b0, 32'd100, 32'd7);
        run_op(32, "s-7/2", 1'b1, 32'hFFFFFFF9, 32'd2);
        run_op(32, "s7/-2", 1'b1, 32'd7, 32'hFFFFFFFE);
        run_op(32, "sMIN/-1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_op(32, "uFFFFFFFF/2", 1'b0, 32'hFFFFFFFF, 32'd2);
        run_op(32, "sFFFFFFFF/2", 1'b1, 32'hFFFFFFFF, 32'd2);
        run_op(32, "u123/0", 1'b0, 32'd123, 32'd0);
        run_op(32, "s-5/0", 1'b1, 32'hFFFFFFFB, 32'd0);
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run_op(32, "rand32", 1'($urandom_range(0, 1)), a, b);
        end
    endtask

    task automatic test_annul;
        int lat;
        bit seen_nz;
        @(negedge clk); drive(32, 1'b1, 1'b0, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk); drive(32, 1'b1, 1'b0, 32'd50, 32'd5, 1'b1);
        @(posedge clk); #1;
        n_cmp++;
        if (rdy32 !== 1'b0 || res32 !== 64'd0) begin
            n_fail++;
            $display("FAIL annul_outputs: got rdy=%b res=%h expected rdy=0 res=0", rdy32, res32);
        end
        // Annul held for one more edge must also suppress a start seen in FREE.
        @(posedge clk); #1;
        @(negedge clk); an32 = 1'b0;
        @(posedge clk);
        wait_ready(32, lat, seen_nz);
        n_cmp++;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL annul_restart_latency: got %0d expected 33", lat);
        end
        n_cmp++;
        if (res32 !== {32'h0, 32'hA}) begin
            n_fail++;
            $display("FAIL annul_restart_result: got %h expected %h", res32, {32'h0, 32'hA});
        end
        $display("[%0t] W=32 annul-then-50/5 result=%h lat=%0d", $time, res32, lat);
        @(negedge clk); st32 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        bit seen_nz;
        @(negedge clk); drive(32, 1'b1, 1'b0, 32'd9999, 32'd7, 1'b0);
        @(posedge clk);
        repeat (20) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy32 !== 1'b0 || res32 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_mid_on: got rdy=%b res=%h expected 0", rdy32, res32);
        end
        @(negedge clk); st32 = 1'b0; rst = 1'b1;
        run_op(32, "u9/3_after_reset", 1'b0, 32'd9, 32'd3);
        // Reset while a result is held must clear the outputs without waiting for an edge.
        @(negedge clk); drive(32, 1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
        @(posedge clk);
        wait_ready(32, lat, seen_nz);
        @(negedge clk); #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (rdy32 !== 1'b0 || res32 !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_in_end_async: got rdy=%b res=%h expected 0", rdy32, res32);
        end
        @(negedge clk); st32 = 1'b0; rst = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_back_to_back;
        run_op(32, "b2b_first", 1'b1, 32'hFFFFFF9C, 32'd9);
        run_op(32, "b2b_second", 1'b0, 32'd77, 32'd0);
        run_op(32, "b2b_third", 1'b1, 32'd12345, 32'hFFFFFFF0);
    endtask

    task automatic test_width8;
        run_op(8, "u100/7_w8", 1'b0, 32'd100, 32'd7);
        run_op(8, "sMIN/-1_w8", 1'b1, 32'h80, 32'hFF);
        run_op(8, "u9/0_w8", 1'b0, 32'd9, 32'd0);
        for (int i = 0; i < 12; i++) begin
            run_op(8, "rand8", 1'($urandom_range(0, 1)), $urandom, 32'($urandom_range(0, 255)));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative radix-2 restoring divider for the openmips EX stage. It supports signed and unsigned modes, a start/ready handshake and annulment. EX issues DIV/DIVU operands and stalls until `ready_o` is asserted. It then forwards `result_o` as {remainder, quotient} into the HI/LO path (HI = remainder, LO = quotient). Operands are captured at start, so the pipeline may change the input buses while the divide runs.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Quotient and remainder are each `WIDTH` bits. Legal range is ≥ 2.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- `opdata1_i`  in  WIDTH  dividend; sampled with start
- `opdata2_i`  in  WIDTH  divisor; sampled with start
- `start_i`  in  1  request; must stay high until the requester has consumed the result
- `annul_i`  in  1  abort the current operation (branch flush or exception)
- `result_o`  out  2*WIDTH  {remainder, quotient}; valid only while `ready_o` = 1, otherwise 0
- `ready_o`  out  1  result valid

## Operation
- States:
  - FREE: idle
  - BYZERO: divisor is zero
  - ON: iterating
  - END: result held
- FREE:
  - On `start_i` = 1 and `annul_i` = 0, latch the operands and the mode.
  - Divisor == 0 → BYZERO.
  - Otherwise → ON with iteration counter = 0.
  - In signed mode, latch absolute values (two's-complement negate if MSB = 1). Record sign flags from the original MSBs.
- BYZERO: → END next edge. Result = all zeros.
- ON, each cycle:
  - Shift {partial remainder, dividend} left by 1.
  - Trial-subtract the divisor from the upper `WIDTH+1` bits.
  - If the difference is non-negative, keep it and set quotient bit = 1; else keep the shifted value and set quotient bit = 0.
  - Counter increments. After the `WIDTH`-th iteration, go to END.
- ON with `annul_i` = 1 → FREE immediately at that edge. Partial state is discarded; `ready_o` is never asserted for the aborted operation.
- END:
  - `result_o` is registered with sign correction.
  - Quotient is negated when the dividend and divisor signs differ (signed mode only).
  - Remainder takes the dividend's sign (signed mode only).
  - Negation is modulo 2^WIDTH, so MIN / −1 yields quotient = MIN and remainder = 0, with no trap.
  - `ready_o` = 1 while in END.
  - `start_i` = 0 at an edge → FREE, which clears `result_o` to 0 and `ready_o` to 0.
  - `start_i` held high → remain in END and hold the result.
- `start_i` changing while in ON or BYZERO has no effect; the operands are already latched.
- `annul_i` in FREE suppresses start. In END it has no effect: the result is still consumed by the `start_i` deassert.

## Timing
- Reset (`rst` = 0, async): state = FREE, counter = 0, `result_o` = 0, `ready_o` = 0. Reset takes effect immediately, including mid-ON; the in-flight operation is lost.
- Start sampled at edge E0. For a non-zero divisor, `ready_o` rises after edge E0+WIDTH+1 (33 edges for WIDTH = 32).
- Zero divisor: `ready_o` rises after edge E0+2.
- Back-to-back operations: `start_i` low for ≥ 1 edge (END→FREE), then high again. Minimum issue interval is WIDTH+3 cycles.
- `result_o` and `ready_o` are registered outputs with no combinational path from any input.

## Test plan
- Unsigned 100 / 7, WIDTH = 32 → after 33 edges `ready_o` = 1 and `result_o` = {32'h2, 32'hE}. Holds while `start_i` = 1. Drop `start_i` → next edge `ready_o` = 0 and `result_o` = 0.
- Signed −7 / 2 → `result_o` = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7 / −2 → {32'h1, 32'hFFFFFFFD}. Signed 0x80000000 / 0xFFFFFFFF → {32'h0, 32'h80000000}.
- Unsigned 0xFFFFFFFF / 2 → {32'h1, 32'h7FFFFFFF}. The same operands in signed mode → {32'hFFFFFFFF, 32'h0}.
- Divide by zero (123 / 0) → `ready_o` after 2 edges, `result_o` = 0.
- Assert `annul_i` at iteration 10 → FREE next edge, `ready_o` stays 0. A new start of 50 / 5 then gives {32'h0, 32'hA} at 33 edges.
- Pull `rst` low mid-ON at iteration 20 → outputs are 0 immediately. After release, 9 / 3 completes normally with {32'h0, 32'h3}. Repeat the 100 / 7 case with WIDTH = 8 → ready after 9 edges, `result_o` = {8'h2, 8'hE}.
